i2s_rx_slave: RTL and testbench
===============================

Name: i2s_rx_slave

Overview:
- Clock-slave I2S receiver: the consumer end of the I2S link driven by the team's BCLK/LRCLK master.
- Samples externally supplied BCLK, LRCLK and SD pins, all asynchronous to `clk`, and oversamples them in the `clk` domain.
- Deserialises standard Philips I2S: 32-bit slots, MSB one BCLK after each LRCLK edge.
- Presents stereo frames on a valid/ready stream to downstream logic (FFT input buffer).

Parameters:
- DATA_WIDTH, 24, bits captured per channel, MSB-first; legal range 8..32; remaining slot bits are ignored.

Ports:
- clk  in  1  system clock; must be ≥ 4× BCLK frequency.
- rst  in  1  synchronous, active-high reset.
- i2s_bclk  in  1  external bit clock, asynchronous.
- i2s_lrclk  in  1  external word select, asynchronous; 0 = left, 1 = right.
- i2s_sd  in  1  external serial data, asynchronous.
- out_left  out  DATA_WIDTH  left sample of the held frame.
- out_right  out  DATA_WIDTH  right sample of the held frame.
- out_valid  out  1  frame available.
- out_ready  in  1  downstream accepts the frame.
- overrun  out  1  1-cycle pulse: a completed frame was dropped.
- frame_err  out  1  1-cycle pulse: slot length error; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, active-high) clears all outputs and state:
  - out_left, out_right, out_valid, overrun, frame_err = 0.
  - FSM = SEEK.
  - Synchroniser flops reset to 0.
- Input path:
  - Each pin passes through a 2-FF synchroniser.
  - A history flop on BCLK produces `bclk_rise` (sync=1, prev=0), one cycle wide.
  - Pin-to-strobe latency: 3 clk.
  - LRCLK and SD are taken from their synchroniser outputs on the `bclk_rise` cycle.
- Each `bclk_rise` samples `lr` and `sd`. `lr_chg` = (lr != lr_prev); lr_prev then updates.
- Bit placement:
  - Per-slot counter `bit_cnt` is 6 bits and saturates at 63.
  - The `sd` bit taken on the k-th rise after a slot start (k = 0..) is written to shift bit DATA_WIDTH-1-k when k < DATA_WIDTH; otherwise it is discarded.
  - The shift register clears at slot start, so short slots are zero-padded in the LSBs.
- Slot end: a rise with lr_chg=1.
  - Its `sd` bit is the final bit of the ending slot (I2S one-bit delay) and is placed before the word is latched.
  - bit_cnt then resets to 0 and the shift register clears.
- FSM (advances only on `bclk_rise`):
  - SEEK: on lr_chg with lr=0 (1→0 edge) → LEFT. All bits before this are ignored.
  - LEFT: on lr_chg (0→1) → latch word into left_hold; → RIGHT.
  - RIGHT: on lr_chg (1→0) → latch word into right_hold; publish frame; → LEFT.
- Publish (the cycle after the completing `bclk_rise`):
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load out_left/out_right from the holds and set out_valid=1.
  - If out_valid=1 and out_ready=0: drop the new frame, hold the old frame unchanged, pulse overrun.
- Handshake:
  - out_valid falls the cycle after out_valid&&out_ready unless a publish coincides.
  - out_left/out_right are stable while out_valid=1.
- The first frame after reset therefore requires a full left+right slot pair following an LRCLK 1→0 edge.
- An LRCLK stuck at one level makes bit_cnt saturate; no output is produced.
- Reset mid-slot discards partial data, and the receiver re-enters SEEK.

Optional Feature:
- Macro: I2S_RX_FRAME_CHECK_EN.
- Enabled:
  - On every slot end in LEFT or RIGHT, the slot must have contained exactly 32 bits (bit_cnt == 31 before the ending rise).
  - On mismatch: pulse frame_err, discard left_hold/right_hold and the frame in progress (no publish), and go to SEEK. If the failing edge is itself a 1→0 edge, go directly to LEFT.
- Disabled:
  - frame_err is constant 0.
  - Any slot length is accepted, with truncation or zero-padding as above.

Decomposition:
- Shared package `i2s_pkg`:
  - SLOT_BITS = 32.
  - BIT_CNT_W = 6.
  - FSM state typedef {SEEK, LEFT, RIGHT}.
- Sub-module `i2s_pin_sync`: 3-bit 2-FF synchroniser plus BCLK rise detector, outputs bclk_rise/lr_s/sd_s; reused by any future I2S slave transmitter.

Test Plan:
- Master model at clk/8 BCLK, 32-bit slots, after an initial LR 1→0; left=0xA5A5A5, right=0x5A5A5A, out_ready=1 → one out_valid pulse with out_left=0xA5A5A5, out_right=0x5A5A5A, overrun=0.
- Same stimulus with out_ready=0 for 2 frames; 2nd frame left=0x123456 → out_valid stays 1, data stays 0xA5A5A5/0x5A5A5A, overrun pulses once; raise out_ready → accepted, out_valid drops.
- Stream starts mid-right-slot with lr=1; first left word 0x800001 → no output until after the first 1→0 edge; first published out_left = 0x800001 exactly.
- DATA_WIDTH=16, slot bits 0xBEEF followed by 16 ones → out_left=0xBEEF, extra bits ignored.
- With I2S_RX_FRAME_CHECK_EN, one left slot of 30 bits → frame_err pulse, no out_valid for that frame, next well-formed frame published. Without the macro, the same stimulus publishes a frame and frame_err=0.
- Assert rst for 1 cycle mid-right-slot → all outputs 0 next cycle; the receiver resumes on the next 1→0 edge and publishes correct data.

Source files
------------

// File: rtl/i2s_rx_slave_pkg.sv
// i2s_rx_slave_pkg: shared I2S slot constants and receiver FSM state type.
package i2s_pkg;
  localparam int SLOT_BITS = 32;
  localparam int BIT_CNT_W = 6;
  typedef enum logic [1:0] {SEEK, LEFT, RIGHT} state_e;
endpackage

// File: rtl/i2s_rx_slave_if.sv
// i2s_rx_slave_if: stereo frame valid/ready stream with overrun and frame error pulses.
interface i2s_rx_slave_if #(parameter int DATA_WIDTH = 24);
  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;
  logic out_valid;
  logic out_ready;
  logic overrun;
  logic frame_err;
  modport master(output out_left, out_right, out_valid, overrun, frame_err, input out_ready);
  modport slave(input out_left, out_right, out_valid, overrun, frame_err, output out_ready);
endinterface

// File: rtl/i2s_rx_slave_pin_sync.sv
// i2s_pin_sync: 2-FF synchronisers for BCLK/LRCLK/SD plus a one-cycle BCLK rise strobe.
module i2s_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic bclk_i,
  input  logic lrclk_i,
  input  logic sd_i,
  output logic bclk_rise_o,
  output logic lr_s_o,
  output logic sd_s_o
);
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic bclk_prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      s1_q <= {sd_i, lrclk_i, bclk_i};
      s2_q <= s1_q;
      bclk_prev_q <= s2_q[0];
    end
  end
  assign bclk_rise_o = s2_q[0] & ~bclk_prev_q;
  assign lr_s_o = s2_q[1];
  assign sd_s_o = s2_q[2];
endmodule

// File: rtl/i2s_rx_slave.sv
// i2s_rx_slave: clock-slave Philips I2S receiver; define I2S_RX_FRAME_CHECK_EN to enforce 32-bit slots.
module i2s_rx_slave
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input logic clk,
  input logic rst,
  input logic i2s_bclk,
  input logic i2s_lrclk,
  input logic i2s_sd,
  i2s_rx_slave_if.master st
);
  localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic rise, lr, sd, lr_chg, len_ok, accept;
  logic [DATA_WIDTH-1:0] shift_wr;
  state_e state_q, state_d;
  logic lr_prev_q, lr_prev_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, left_hold_q, left_hold_d, right_hold_q, right_hold_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic valid_q, valid_d, pub_q, pub_d, ovr_q, ovr_d, err_q, err_d;
  i2s_pin_sync u_sync (
    .clk(clk),
    .rst(rst),
    .bclk_i(i2s_bclk),
    .lrclk_i(i2s_lrclk),
    .sd_i(i2s_sd),
    .bclk_rise_o(rise),
    .lr_s_o(lr),
    .sd_s_o(sd)
  );
`ifdef I2S_RX_FRAME_CHECK_EN
  assign len_ok = cnt_q == BIT_CNT_W'(SLOT_BITS - 1);
`else
  assign len_ok = 1'b1;
`endif
  always_comb begin
    lr_chg = rise && (lr != lr_prev_q);
    // Bits past DATA_WIDTH shift the marker out entirely and are dropped.
    shift_wr = shift_q | ({DATA_WIDTH{sd}} & (MSB >> cnt_q));
    lr_prev_d = rise ? lr : lr_prev_q;
    cnt_d = !rise ? cnt_q : lr_chg ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    shift_d = !rise ? shift_q : lr_chg ? '0 : shift_wr;
    state_d = state_q;
    left_hold_d = left_hold_q;
    right_hold_d = right_hold_q;
    pub_d = 1'b0;
    err_d = 1'b0;
    if (lr_chg) begin
      if (state_q == SEEK) begin
        state_d = lr ? SEEK : LEFT;
      end else if (!len_ok) begin
        err_d = 1'b1;
        left_hold_d = '0;
        right_hold_d = '0;
        state_d = lr ? SEEK : LEFT;
      end else if (state_q == LEFT) begin
        left_hold_d = shift_wr;
        state_d = RIGHT;
      end else begin
        right_hold_d = shift_wr;
        pub_d = 1'b1;
        state_d = LEFT;
      end
    end
    accept = pub_q && (!valid_q || st.out_ready);
    valid_d = accept || (valid_q && !st.out_ready);
    left_d = accept ? left_hold_q : left_q;
    right_d = accept ? right_hold_q : right_q;
    ovr_d = pub_q && valid_q && !st.out_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEEK;
      lr_prev_q <= 1'b0;
      cnt_q <= '0;
      shift_q <= '0;
      left_hold_q <= '0;
      right_hold_q <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      pub_q <= 1'b0;
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lr_prev_q <= lr_prev_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      left_hold_q <= left_hold_d;
      right_hold_q <= right_hold_d;
      left_q <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      pub_q <= pub_d;
      ovr_q <= ovr_d;
      err_q <= err_d;
    end
  end
  assign st.out_left = left_q;
  assign st.out_right = right_q;
  assign st.out_valid = valid_q;
  assign st.overrun = ovr_q;
  assign st.frame_err = err_q;
endmodule

// File: tb/tb_i2s_rx_slave.sv
// tb_i2s_rx_slave: directed I2S master model driving 24-bit and 16-bit receivers.
module tb_i2s_rx_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrclk = 1'b1;
  logic sd = 1'b0;
  logic pend = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_ovr = 0;
  int n_ferr = 0;
  logic [23:0] last_l = '0;
  logic [23:0] last_r = '0;
  logic [15:0] l16 = '0;
  logic [15:0] r16 = '0;
  i2s_rx_slave_if #(.DATA_WIDTH(24)) s24 ();
  i2s_rx_slave_if #(.DATA_WIDTH(16)) s16 ();
  i2s_rx_slave #(.DATA_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sd(sd), .st(s24)
  );
  i2s_rx_slave #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sd(sd), .st(s16)
  );
  assign s16.out_ready = 1'b1;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (s24.out_valid && s24.out_ready) begin
      n_acc <= n_acc + 1;
      last_l <= s24.out_left;
      last_r <= s24.out_right;
    end
    if (s24.overrun) n_ovr <= n_ovr + 1;
    if (s24.frame_err) n_ferr <= n_ferr + 1;
    if (s16.out_valid) begin
      l16 <= s16.out_left;
      r16 <= s16.out_right;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic l, input logic d);
    bclk = 1'b0;
    lrclk = l;
    sd = d;
    repeat (4) tick();
    bclk = 1'b1;
    repeat (4) tick();
  endtask
  // First period carries the previous slot's last bit (one-bit I2S delay).
  task automatic slot(input logic l, input logic [31:0] w, input int n);
    bit_out(l, pend);
    for (int i = 1; i < n; i++) bit_out(l, w[32-i]);
    pend = w[32-n];
  endtask
  task automatic frame(input logic [31:0] l, input logic [31:0] r);
    slot(1'b0, l, 32);
    slot(1'b1, r, 32);
  endtask
  task automatic close_stream();
    bit_out(1'b0, pend);
    pend = 1'b0;
    repeat (3) bit_out(1'b0, 1'b0);
    repeat (8) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b1;
    sd = 1'b0;
    pend = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) bit_out(1'b1, 1'b0);
  endtask
  task automatic test_reset();
    s24.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (s24.out_left !== 24'h0) begin n_fail++; $display("FAIL reset_left: got %h want 000000", s24.out_left); end
    n_tests++; if (s24.out_right !== 24'h0) begin n_fail++; $display("FAIL reset_right: got %h want 000000", s24.out_right); end
    n_tests++; if (s24.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", s24.out_valid); end
    n_tests++; if (s24.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", s24.overrun); end
    n_tests++; if (s24.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", s24.frame_err); end
  endtask
  task automatic test_basic();
    int a0, o0;
    do_reset();
    s24.out_ready = 1'b1;
    a0 = n_acc; o0 = n_ovr;
    frame({24'hA5A5A5, 8'h00}, {24'h5A5A5A, 8'h00});
    close_stream();
    n_tests++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", n_acc - a0); end
    n_tests++; if (last_l !== 24'hA5A5A5) begin n_fail++; $display("FAIL basic_left: got %h want a5a5a5", last_l); end
    n_tests++; if (last_r !== 24'h5A5A5A) begin n_fail++; $display("FAIL basic_right: got %h want 5a5a5a", last_r); end
    n_tests++; if (n_ovr - o0 !== 0) begin n_fail++; $display("FAIL basic_overrun: got %0d want 0", n_ovr - o0); end
    n_tests++; if (s24.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", s24.out_valid); end
    n_tests++; if (l16 !== 16'hA5A5) begin n_fail++; $display("FAIL basic_w16_left: got %h want a5a5", l16); end
  endtask
  task automatic test_overrun();
    int a0, o0;
    do_reset();
    s24.out_ready = 1'b0;
    a0 = n_acc; o0 = n_ovr;
    frame({24'hA5A5A5, 8'h00}, {24'h5A5A5A, 8'h00});
    frame({24'h123456, 8'h00}, {24'h654321, 8'h00});
    close_stream();
    n_tests++; if (s24.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", s24.out_valid); end
    n_tests++; if (s24.out_left !== 24'hA5A5A5) begin n_fail++; $display("FAIL ovr_left_held: got %h want a5a5a5", s24.out_left); end
    n_tests++; if (s24.out_right !== 24'h5A5A5A) begin n_fail++; $display("FAIL ovr_right_held: got %h want 5a5a5a", s24.out_right); end
    n_tests++; if (n_ovr - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - o0); end
    s24.out_ready = 1'b1;
    repeat (3) tick();
    n_tests++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL ovr_accept: got %0d want 1", n_acc - a0); end
    n_tests++; if (last_l !== 24'hA5A5A5) begin n_fail++; $display("FAIL ovr_accept_left: got %h want a5a5a5", last_l); end
    n_tests++; if (s24.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", s24.out_valid); end
  endtask
  task automatic test_mid_start();
    int a0;
    do_reset();
    s24.out_ready = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 12; i++) bit_out(1'b1, i[0]);
    repeat (8) tick();
    n_tests++; if (n_acc - a0 !== 0) begin n_fail++; $display("FAIL mid_no_early: got %0d want 0", n_acc - a0); end
    frame({24'h800001, 8'h00}, {24'h00ABCD, 8'h00});
    close_stream();
    n_tests++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", n_acc - a0); end
    n_tests++; if (last_l !== 24'h800001) begin n_fail++; $display("FAIL mid_left: got %h want 800001", last_l); end
    n_tests++; if (last_r !== 24'h00ABCD) begin n_fail++; $display("FAIL mid_right: got %h want 00abcd", last_r); end
  endtask
  task automatic test_width16();
    do_reset();
    s24.out_ready = 1'b1;
    frame(32'hBEEF_FFFF, 32'h1234_0000);
    close_stream();
    n_tests++; if (l16 !== 16'hBEEF) begin n_fail++; $display("FAIL w16_left: got %h want beef", l16); end
    n_tests++; if (r16 !== 16'h1234) begin n_fail++; $display("FAIL w16_right: got %h want 1234", r16); end
    n_tests++; if (last_l !== 24'hBEEFFF) begin n_fail++; $display("FAIL w24_left: got %h want beefff", last_l); end
  endtask
  task automatic test_short_slot();
    int a0, f0;
    do_reset();
    s24.out_ready = 1'b1;
    a0 = n_acc; f0 = n_ferr;
    slot(1'b0, {24'hA5A5A5, 8'h00}, 30);
    slot(1'b1, {24'h5A5A5A, 8'h00}, 32);
    frame({24'h3C3C3C, 8'h00}, {24'hC3C3C3, 8'h00});
    close_stream();
`ifdef I2S_RX_FRAME_CHECK_EN
    n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL short_frame_err: got %0d want 1", n_ferr - f0); end
    n_tests++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL short_count: got %0d want 1", n_acc - a0); end
`else
    n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL short_frame_err: got %0d want 0", n_ferr - f0); end
    n_tests++; if (n_acc - a0 !== 2) begin n_fail++; $display("FAIL short_count: got %0d want 2", n_acc - a0); end
`endif
    n_tests++; if (last_l !== 24'h3C3C3C) begin n_fail++; $display("FAIL short_next_left: got %h want 3c3c3c", last_l); end
    n_tests++; if (last_r !== 24'hC3C3C3) begin n_fail++; $display("FAIL short_next_right: got %h want c3c3c3", last_r); end
  endtask
  task automatic test_reset_mid();
    int a0;
    do_reset();
    s24.out_ready = 1'b0;
    frame({24'hA5A5A5, 8'h00}, {24'h5A5A5A, 8'h00});
    slot(1'b0, {24'h123456, 8'h00}, 32);
    for (int i = 0; i < 10; i++) bit_out(1'b1, 1'b1);
    n_tests++; if (s24.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b want 1", s24.out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (s24.out_left !== 24'h0) begin n_fail++; $display("FAIL rmid_left: got %h want 000000", s24.out_left); end
    n_tests++; if (s24.out_right !== 24'h0) begin n_fail++; $display("FAIL rmid_right: got %h want 000000", s24.out_right); end
    n_tests++; if (s24.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", s24.out_valid); end
    s24.out_ready = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 22; i++) bit_out(1'b1, 1'b0);
    pend = 1'b0;
    frame({24'h0F0F0F, 8'h00}, {24'hF0F0F0, 8'h00});
    close_stream();
    n_tests++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", n_acc - a0); end
    n_tests++; if (last_l !== 24'h0F0F0F) begin n_fail++; $display("FAIL rmid_resume_left: got %h want 0f0f0f", last_l); end
    n_tests++; if (last_r !== 24'hF0F0F0) begin n_fail++; $display("FAIL rmid_resume_right: got %h want f0f0f0", last_r); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_mid_start();
    test_width16();
    test_short_slot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
